// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: state codes,
// opcodes, ALUOp values and the decoded strobe bundle.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       pcwritecond;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
  } ctrl_t;

  // States that complete an instruction and hand back to FETCH.
  function automatic logic is_retire(state_e s);
    return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_RWB) ||
           (s == S_BRANCH) || (s == S_JUMP) || (s == S_IWB);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: opcode/zero in, strobes and status out.
interface multicycle_ctrl_if;
  logic [5:0] op;
  logic       zero;
  logic       aluop1, aluop0;
  logic       pcwrite, pcwritecond, pcen;
  logic       iord, memread, memwrite, irwrite, memtoreg, regwrite, regdst, alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsource;
  logic [3:0] state;
  logic       illegal;
  logic       instr_done;

  modport master (
    input  op, zero,
    output aluop1, aluop0, pcwrite, pcwritecond, pcen,
           iord, memread, memwrite, irwrite, memtoreg, regwrite, regdst, alusrca,
           alusrcb, pcsource, state, illegal, instr_done
  );

  modport slave (
    output op, zero,
    input  aluop1, aluop0, pcwrite, pcwritecond, pcen,
           iord, memread, memwrite, irwrite, memtoreg, regwrite, regdst, alusrca,
           alusrcb, pcsource, state, illegal, instr_done
  );
endinterface

// File: rtl/multicycle_ctrl_dec.sv
// Moore output decode: registered state in, raw datapath strobes out.
module multicycle_ctrl_dec
  import mips_ctrl_pkg::*;
(
  input  state_e state_i,
  output ctrl_t  ctl_o
);

  always_comb begin
    ctl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctl_o.memread  = 1'b1;
        ctl_o.irwrite  = 1'b1;
        ctl_o.pcwrite  = 1'b1;
        ctl_o.alusrcb  = SRCB_FOUR;
        ctl_o.aluop    = ALUOP_ADD;
        ctl_o.pcsource = PCSRC_ALU;
      end
      S_DECODE: begin
        ctl_o.alusrcb = SRCB_IMMSH;
        ctl_o.aluop   = ALUOP_ADD;
      end
      S_MEMADR, S_IEXEC: begin
        ctl_o.alusrca = 1'b1;
        ctl_o.alusrcb = SRCB_IMM;
        ctl_o.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctl_o.memread = 1'b1;
        ctl_o.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctl_o.regwrite = 1'b1;
        ctl_o.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        ctl_o.memwrite = 1'b1;
        ctl_o.iord     = 1'b1;
      end
      S_EXEC: begin
        ctl_o.alusrca = 1'b1;
        ctl_o.alusrcb = SRCB_REG;
        ctl_o.aluop   = ALUOP_RTYPE;
      end
      S_RWB: begin
        ctl_o.regwrite = 1'b1;
        ctl_o.regdst   = 1'b1;
      end
      S_BRANCH: begin
        ctl_o.alusrca     = 1'b1;
        ctl_o.alusrcb     = SRCB_REG;
        ctl_o.aluop       = ALUOP_SUB;
        ctl_o.pcwritecond = 1'b1;
        ctl_o.pcsource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctl_o.pcwrite  = 1'b1;
        ctl_o.pcsource = PCSRC_JUMP;
      end
      S_IWB: ctl_o.regwrite = 1'b1;
      default: ctl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: state register, next-state logic, status pulses.
// Optional bne support is enabled with `define MULTICYCLE_CTRL_BNE_EN.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  multicycle_ctrl_if.master  bus
);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   done_q, done_d;
  logic   br_taken;
  ctrl_t  ctl;

  always_comb begin
    state_d   = S_FETCH;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef MULTICYCLE_CTRL_BNE_EN
          OP_BNE:       state_d = S_BRANCH;
`endif
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_IEXEC;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_RWB;
      S_IEXEC:  state_d = S_IWB;
      default:  state_d = S_FETCH;
    endcase
    done_d = is_retire(state_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      done_q    <= done_d;
    end
  end

`ifdef MULTICYCLE_CTRL_BNE_EN
  // Remembers which compare sense the instruction in flight wants in BRANCH.
  logic bne_q;
  always_ff @(posedge clk) begin
    if (state_q == S_DECODE) bne_q <= (bus.op == OP_BNE);
  end
  assign br_taken = bne_q ? ~bus.zero : bus.zero;
`else
  assign br_taken = bus.zero;
`endif

  multicycle_ctrl_dec u_dec (
    .state_i (state_q),
    .ctl_o   (ctl)
  );

  // Architectural write/read strobes are held off for the whole reset cycle.
  assign bus.memread     = ctl.memread     & ~reset;
  assign bus.memwrite    = ctl.memwrite    & ~reset;
  assign bus.irwrite     = ctl.irwrite     & ~reset;
  assign bus.pcwrite     = ctl.pcwrite     & ~reset;
  assign bus.pcwritecond = ctl.pcwritecond & ~reset;
  assign bus.regwrite    = ctl.regwrite    & ~reset;
  assign bus.pcen        = ~reset & (ctl.pcwrite | (ctl.pcwritecond & br_taken));

  assign bus.regdst      = ctl.regdst;
  assign bus.memtoreg    = ctl.memtoreg;
  assign bus.iord        = ctl.iord;
  assign bus.alusrca     = ctl.alusrca;
  assign bus.alusrcb     = ctl.alusrcb;
  assign bus.pcsource    = ctl.pcsource;
  assign bus.aluop1      = ctl.aluop[1];
  assign bus.aluop0      = ctl.aluop[0];
  assign bus.state       = state_q;
  assign bus.illegal     = illegal_q;
  assign bus.instr_done  = done_q;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL: clk  input  1  single clock, all state changes on rising edge.
REQ-002 SHALL: reset  input  1  synchronous, active-high; sampled on rising edge of clk.
REQ-003 SHALL: op  input  6  opcode field, taken from the instruction register.
REQ-004 SHALL: zero  input  1  ALU zero flag.
REQ-005 SHALL: aluop1, aluop0  output  1 each  ALUOp pair for the downstream ALU control unit.
- Encoding: 00 = add (load/store/addi/fetch/decode); 01 = branch compare (subtract); 10 = R-type, decode funct.
REQ-006 SHALL: pcwrite, pcwritecond, pcen  output  1 each  PC write controls.
- pcen = pcwrite | (pcwritecond & branch condition).
REQ-007 SHALL: iord, memread, memwrite, irwrite, memtoreg, regwrite, regdst, alusrca  output  1 each  datapath strobes and select lines.
REQ-008 SHALL: alusrcb  output  2  ALU B select: 00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
REQ-009 SHALL: pcsource  output  2  PC source select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-010 SHALL: state  output  4  current state code; illegal  output  1  illegal-opcode pulse; instr_done  output  1  instruction-retire pulse.

Function
REQ-011 SHALL: be a Moore FSM; all outputs except pcen decode from the registered state only.
- pcen is combinational from state and zero.
REQ-012 SHALL: use these state codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11.
- Codes 12-15 SHALL go to FETCH on the next edge.
REQ-013 SHALL: in FETCH, assert memread, irwrite, pcwrite, alusrcb=01, aluop=00, pcsource=00, iord=0, alusrca=0; next state DECODE.
REQ-014 SHALL: in DECODE, drive alusrca=0, alusrcb=11, aluop=00 (branch target into ALUOut), then branch on op:
- 100011 (lw) or 101011 (sw) -> MEMADR
- 000000 -> EXEC
- 000100 (beq) -> BRANCH
- 000010 (j) -> JUMP
- 001000 (addi) -> IEXEC
- any other op -> FETCH
REQ-015 SHALL: in MEMADR, drive alusrca=1, alusrcb=10, aluop=00; next state MEMRD for lw, MEMWR for sw.
REQ-016 SHALL: in MEMRD, assert memread with iord=1 -> MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0 -> FETCH.
- MEMWR: memwrite=1, iord=1 -> FETCH.
REQ-017 SHALL: in EXEC, drive alusrca=1, alusrcb=00, aluop=10 -> RWB.
- RWB: regwrite=1, regdst=1, memtoreg=0 -> FETCH.
REQ-018 SHALL: in BRANCH, drive alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01 -> FETCH.
- pcen = zero in this state.
REQ-019 SHALL: in JUMP, drive pcwrite=1, pcsource=10 -> FETCH.
REQ-020 SHALL: in IEXEC, drive alusrca=1, alusrcb=10, aluop=00 -> IWB.
- IWB: regwrite=1, regdst=0, memtoreg=0 -> FETCH.
REQ-021 SHALL: in every state, deassert all strobes not listed for that state.
- Unlisted select lines SHALL be 0.
REQ-022 SHALL: raise illegal for exactly one cycle, registered, in the cycle after DECODE when the opcode falls in the "any other op" branch of REQ-014.
REQ-023 SHALL: raise instr_done for exactly one cycle, registered, in the cycle after any state whose next state is FETCH.
- Excluded: illegal-opcode exits and the reset cycle.
REQ-024 SHALL: have these instruction latencies in cycles: lw 5; sw, R-type, addi 4; beq, j 3; illegal opcode 2.

Reset
REQ-025 SHALL: on reset=1 at a clock edge, set state=FETCH and clear illegal and instr_done to 0.
- This holds whatever the current state, including mid-instruction; the partial instruction is abandoned.
REQ-026 SHALL: while reset is asserted, drive memwrite, regwrite, pcwrite, pcwritecond, irwrite and memread to 0, regardless of state.
- The first FETCH strobes SHALL appear in the first cycle with reset=0.

Configuration
REQ-027 SHALL: provide macro MULTICYCLE_CTRL_BNE_EN.
- When defined: opcode 000101 (bne) goes DECODE -> BRANCH with the same outputs as beq, and pcen = pcwritecond & ~zero for that instruction.
- To support this, a 1-bit registered flag captured in DECODE selects eq/ne.
- When undefined: 000101 is illegal per REQ-014 and REQ-022, and no flag is synthesised.

Structure
REQ-028 SHALL: place state codes, opcode constants and ALUOp encodings in shared package mips_ctrl_pkg, which the ALU control unit also uses.
REQ-029 SHALL: split into two parts: next-state logic/state register in this module, and output decode in sub-module multicycle_ctrl_dec (state in, strobes out).

Verification
REQ-030 SHALL: cover these directed scenarios.
- reset high 2 cycles, op=100011 -> state sequence 0,1,2,3,4,0; regwrite=1 only in state 4; instr_done pulse after state 4.
- op=000100 with zero=1 -> pcen=1 in BRANCH; repeat with zero=0 -> pcen=0; aluop1/aluop0=0/1 in both runs.
- op=000000 -> aluop=10 in EXEC; regdst=1 and regwrite=1 in RWB; 4 cycles total.
- op=111111 -> illegal=1 for one cycle; state returns 0 after DECODE; no write strobes asserted.
- reset asserted while in MEMWR -> memwrite=0 in that cycle; state=0 next; illegal=0 and instr_done=0.
- with MULTICYCLE_CTRL_BNE_EN: op=000101 and zero=0 -> pcen=1; without the macro, the same op -> illegal=1.
